mul_mdc_stream_feeder: RTL

Stream-side counterpart of the mul_mdc MAC accelerator. It buffers operand pairs written by the host into a local FIFO and transmits them as the accelerator's a/b input streams, grouped into jobs of (len+1) elements. It also sinks the accelerator's d result stream, counting and accumulating results until the programmed number of jobs is complete. It sits between the host/DMA operand port and the mul_mdc a/b/d stream ports.

---
 rtl/mul_mdc_stream_feeder.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/mul_mdc_stream_feeder.sv
// Operand/result stream feeder for the mul_mdc MAC accelerator.
// Host operand pairs are queued in a small FIFO and sent as the a/b streams,
// grouped into jobs of (len+1) elements. The d result stream is counted and
// accumulated until all results expected for the programmed jobs have arrived.
module mul_mdc_stream_feeder #(
   parameter int DEPTH       = 8,
   parameter int MAC_CNT_LEN = 4096,
   parameter int JOB_W       = 16
) (
   input  logic                           ap_clk,
   input  logic                           ap_rst_n,
   input  logic                           in_TVALID,
   output logic                           in_TREADY,
   input  logic [63:0]                    in_TDATA,
   output logic                           a_TVALID,
   input  logic                           a_TREADY,
   output logic [31:0]                    a_TDATA,
   output logic                           b_TVALID,
   input  logic                           b_TREADY,
   output logic [31:0]                    b_TDATA,
   input  logic                           d_TVALID,
   output logic                           d_TREADY,
   input  logic [31:0]                    d_TDATA,
   input  logic                           start,
   input  logic                           reg_simple_mul,
   input  logic [$clog2(MAC_CNT_LEN)-1:0] reg_len,
   input  logic [JOB_W-1:0]               reg_num_jobs,
   output logic                           busy,
   output logic                           done,
   output logic [31:0]                    res_count,
   output logic [31:0]                    res_sum,
   output logic [31:0]                    res_last
);

   localparam int LEN_W = $clog2(MAC_CNT_LEN);
   localparam int PTR_W = $clog2(DEPTH);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN,
      DONE
   } state_t;

   state_t state;
   state_t state_next;

   logic [63:0]      mem [DEPTH];
   logic [63:0]      head;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W:0]   occupancy;
   logic             full;
   logic             empty;
   logic             accept_en;

   logic             push;
   logic             pop;
   logic             res_hs;
   logic             start_ok;
   logic             last_pop;
   logic             last_res;

   logic             simple_q;
   logic [LEN_W-1:0] len_q;
   logic [JOB_W-1:0] jobs_q;
   logic [JOB_W-1:0] jobs_last;

   logic [LEN_W-1:0] tx_elem;
   logic [JOB_W-1:0] tx_job;
   logic [LEN_W-1:0] rx_elem;
   logic [JOB_W-1:0] rx_job;

   assign full      = (occupancy == (PTR_W+1)'(DEPTH));
   assign empty     = (occupancy == '0);
   assign head      = mem[rd_ptr];

   assign in_TREADY = accept_en & ~full;
   assign a_TVALID  = (state == RUN) & ~empty;
   assign b_TVALID  = (state == RUN) & ~empty;
   assign a_TDATA   = head[31:0];
   assign b_TDATA   = head[63:32];
   assign d_TREADY  = (state == RUN) | (state == DRAIN);
   assign busy      = (state != IDLE);
   assign done      = (state == DONE);

   assign push      = in_TVALID & in_TREADY;
   assign pop       = a_TVALID & a_TREADY & b_TREADY;
   assign res_hs    = d_TVALID & d_TREADY;
   assign start_ok  = start & (state == IDLE);
   assign jobs_last = jobs_q - JOB_W'(1);
   assign last_pop  = pop & (tx_elem == len_q) & (tx_job == jobs_last);
   assign last_res  = res_hs & (~simple_q | (rx_elem == len_q)) & (rx_job == jobs_last);

   // Hold off host writes until the first clock after reset is released
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         accept_en <= 1'b0;
      end else begin
         accept_en <= 1'b1;
      end
   end

   // Operand storage; contents are don't-care while the pointers say empty
   always_ff @(posedge ap_clk) begin
      if (push) begin
         mem[wr_ptr] <= in_TDATA;
      end
   end

   // FIFO pointers and occupancy, flushed by reset
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         occupancy <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         if (push && !pop) begin
            occupancy <= occupancy + (PTR_W+1)'(1);
         end else if (pop && !push) begin
            occupancy <= occupancy - (PTR_W+1)'(1);
         end
      end
   end

   // State register
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic; the final result wins over the final pop so DRAIN is skipped
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (start) begin
               state_next = (reg_num_jobs == '0) ? DONE : RUN;
            end
         end
         RUN: begin
            if (last_res) begin
               state_next = DONE;
            end else if (last_pop) begin
               state_next = DRAIN;
            end
         end
         DRAIN: begin
            if (last_res) begin
               state_next = DONE;
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Config capture, nested transmit/receive counters and result statistics
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         simple_q  <= 1'b0;
         len_q     <= '0;
         jobs_q    <= '0;
         tx_elem   <= '0;
         tx_job    <= '0;
         rx_elem   <= '0;
         rx_job    <= '0;
         res_count <= '0;
         res_sum   <= '0;
         res_last  <= '0;
      end else if (start_ok) begin
         simple_q  <= reg_simple_mul;
         len_q     <= reg_len;
         jobs_q    <= reg_num_jobs;
         tx_elem   <= '0;
         tx_job    <= '0;
         rx_elem   <= '0;
         rx_job    <= '0;
         res_count <= '0;
         res_sum   <= '0;
         res_last  <= '0;
      end else begin
         if (pop) begin
            if (tx_elem == len_q) begin
               tx_elem <= '0;
               tx_job  <= tx_job + JOB_W'(1);
            end else begin
               tx_elem <= tx_elem + LEN_W'(1);
            end
         end
         if (res_hs) begin
            res_count <= res_count + 32'd1;
            res_sum   <= res_sum + d_TDATA;
            res_last  <= d_TDATA;
            if (!simple_q || (rx_elem == len_q)) begin
               rx_elem <= '0;
               rx_job  <= rx_job + JOB_W'(1);
            end else begin
               rx_elem <= rx_elem + LEN_W'(1);
            end
         end
      end
   end

endmodule
